// File: rtl/ro_meas_sequencer_pkg.sv
// Shared types and constants for the ring-oscillator measurement sequencer and its UART framer.

package ro_meas_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSel,
    StSettle,
    StWindow,
    StDrain,
    StAccum,
    StSend
  } seq_state_e;

  typedef enum logic [2:0] {
    FrIdle,
    FrWait,
    FrStrobe,
    FrSkip,
    FrFinish
  } fr_state_e;

  localparam logic [7:0] HdrByte = 8'hA5;
  localparam logic       OscInv  = 1'b0;
  localparam logic       OscNand = 1'b1;

  // Packet layout, first byte in the top octet: header, id, avg high, avg low.
  function automatic logic [31:0] pack_pkt(input logic ovf, input logic osc,
                                           input logic [15:0] avg);
    return {HdrByte, ovf, 6'b000000, osc, avg};
  endfunction

endpackage

// File: rtl/meas_tx_framer.sv
// Streams a 4-byte packet through the UART tx handshake; can stop after the byte in flight.

module meas_tx_framer
  import ro_meas_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] pkt_i,
  input  logic        abort_i,
  input  logic        tx_busy_i,
  output logic        tx_start_o,
  output logic [7:0]  tx_data_o,
  output logic        pkt_done_o,
  output logic        stopped_o
);

  fr_state_e   state_q;
  logic [31:0] pkt_q;
  logic [1:0]  idx_q;
  logic        abort_q;
  logic        stop;

  assign stop = abort_i | abort_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FrIdle;
      pkt_q      <= '0;
      idx_q      <= '0;
      abort_q    <= 1'b0;
      tx_start_o <= 1'b0;
      tx_data_o  <= '0;
      pkt_done_o <= 1'b0;
      stopped_o  <= 1'b0;
    end else begin
      tx_start_o <= 1'b0;
      pkt_done_o <= 1'b0;
      stopped_o  <= 1'b0;
      abort_q    <= (state_q != FrIdle) && stop;
      unique case (state_q)
        FrIdle: begin
          if (load_i) begin
            pkt_q   <= pkt_i;
            idx_q   <= '0;
            state_q <= FrWait;
          end
        end
        FrWait: begin
          if (stop) begin
            stopped_o <= 1'b1;
            state_q   <= FrIdle;
          end else if (!tx_busy_i) begin
            tx_start_o <= 1'b1;
            tx_data_o  <= pkt_q[31:24];
            pkt_q      <= {pkt_q[23:0], 8'h00};
            state_q    <= FrStrobe;
          end
        end
        // The UART may not raise busy until after the strobe, so two cycles are ignored.
        FrStrobe: state_q <= FrSkip;
        FrSkip:   state_q <= FrFinish;
        FrFinish: begin
          if (!tx_busy_i) begin
            if (stop) begin
              stopped_o <= 1'b1;
              state_q   <= FrIdle;
            end else if (idx_q == 2'd3) begin
              pkt_done_o <= 1'b1;
              state_q    <= FrIdle;
            end else begin
              idx_q      <= idx_q + 2'd1;
              tx_start_o <= 1'b1;
              tx_data_o  <= pkt_q[31:24];
              pkt_q      <= {pkt_q[23:0], 8'h00};
              state_q    <= FrStrobe;
            end
          end
        end
        default: state_q <= FrIdle;
      endcase
    end
  end

endmodule

// File: rtl/ro_meas_sequencer.sv
// Time-shares the edge counter between the inverter and NAND ring oscillators, averages
// 2^NSampLog2 gated windows per oscillator and sends one framed packet per oscillator.

module ro_meas_sequencer
  import ro_meas_sequencer_pkg::*;
#(
  parameter int unsigned CntW      = 16,
  parameter int unsigned Window    = 10000,
  parameter int unsigned Guard     = 4,
  parameter int unsigned NSampLog2 = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [1:0]      osc_mask_i,
  input  logic            abort_i,
  input  logic [CntW-1:0] cnt_value_i,
  input  logic            tx_busy_i,
  output logic            en_inv_o,
  output logic            en_nand_o,
  output logic            osc_sel_o,
  output logic            cnt_clear_o,
  output logic            tx_start_o,
  output logic [7:0]      tx_data_o,
  output logic            busy_o,
  output logic            done_o
);

  localparam int unsigned AccW     = CntW + NSampLog2;
  localparam int unsigned TimerMax = (Window > Guard) ? Window : Guard;
  localparam int unsigned TimerW   = $clog2(TimerMax);
  localparam int unsigned IdxW     = (NSampLog2 > 0) ? NSampLog2 : 1;

  localparam logic [TimerW-1:0] WinLast   = TimerW'(Window - 1);
  localparam logic [TimerW-1:0] GuardLast = TimerW'(Guard - 1);
  localparam logic [TimerW-1:0] ClearAt   = TimerW'(Guard - 2);
  localparam logic [IdxW-1:0]   IdxLast   = IdxW'((1 << NSampLog2) - 1);

  seq_state_e        state_q;
  logic [1:0]        mask_q;
  logic [IdxW-1:0]   idx_q;
  logic [TimerW-1:0] timer_q;
  logic [AccW-1:0]   acc_q;
  logic              ovf_q;
  logic              en_inv_q;
  logic              en_nand_q;
  logic              osc_sel_q;
  logic              cnt_clear_q;
  logic              busy_q;
  logic              done_q;

  logic [AccW-1:0]   acc_sum;
  logic              ovf_sum;
  logic [15:0]       avg16;
  logic              last_sample;
  logic [1:0]        mask_rem;
  logic              fr_load;
  logic [31:0]       fr_pkt;
  logic              fr_pkt_done;
  logic              fr_stopped;

  assign acc_sum     = acc_q + AccW'(cnt_value_i);
  assign ovf_sum     = ovf_q | (&cnt_value_i);
  // Truncating average, zero-extended or cut to the 16-bit packet field.
  assign avg16       = 16'(acc_sum >> NSampLog2);
  assign last_sample = (idx_q == IdxLast);
  assign mask_rem    = (osc_sel_q == OscNand) ? {1'b0, mask_q[0]} : {mask_q[1], 1'b0};
  assign fr_load     = (state_q == StAccum) && last_sample && !abort_i;
  assign fr_pkt      = pack_pkt(ovf_sum, osc_sel_q, avg16);

  meas_tx_framer u_framer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (fr_load),
    .pkt_i      (fr_pkt),
    .abort_i    (abort_i),
    .tx_busy_i  (tx_busy_i),
    .tx_start_o (tx_start_o),
    .tx_data_o  (tx_data_o),
    .pkt_done_o (fr_pkt_done),
    .stopped_o  (fr_stopped)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      mask_q      <= '0;
      idx_q       <= '0;
      timer_q     <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      en_inv_q    <= 1'b0;
      en_nand_q   <= 1'b0;
      osc_sel_q   <= 1'b0;
      cnt_clear_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cnt_clear_q <= 1'b0;
      done_q      <= 1'b0;
      // SEND aborts are handled by the framer so the byte in flight can finish.
      if (abort_i && (state_q inside {StSel, StSettle, StWindow, StDrain, StAccum})) begin
        state_q   <= StIdle;
        mask_q    <= '0;
        en_inv_q  <= 1'b0;
        en_nand_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_i && !abort_i && (osc_mask_i != 2'b00)) begin
              mask_q  <= osc_mask_i;
              busy_q  <= 1'b1;
              state_q <= StSel;
            end
          end
          StSel: begin
            osc_sel_q <= mask_q[0] ? OscInv : OscNand;
            idx_q     <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            timer_q   <= '0;
            state_q   <= StSettle;
          end
          StSettle: begin
            if (timer_q == GuardLast) begin
              timer_q   <= '0;
              en_inv_q  <= (osc_sel_q == OscInv);
              en_nand_q <= (osc_sel_q == OscNand);
              state_q   <= StWindow;
            end else begin
              timer_q     <= timer_q + TimerW'(1);
              cnt_clear_q <= (timer_q == ClearAt);
            end
          end
          StWindow: begin
            if (timer_q == WinLast) begin
              timer_q   <= '0;
              en_inv_q  <= 1'b0;
              en_nand_q <= 1'b0;
              state_q   <= StDrain;
            end else begin
              timer_q <= timer_q + TimerW'(1);
            end
          end
          StDrain: begin
            if (timer_q == GuardLast) begin
              timer_q <= '0;
              state_q <= StAccum;
            end else begin
              timer_q <= timer_q + TimerW'(1);
            end
          end
          StAccum: begin
            acc_q <= acc_sum;
            ovf_q <= ovf_sum;
            if (last_sample) begin
              state_q <= StSend;
            end else begin
              idx_q   <= idx_q + IdxW'(1);
              state_q <= StSettle;
            end
          end
          StSend: begin
            if (fr_pkt_done) begin
              mask_q <= mask_rem;
              if (mask_rem != 2'b00) begin
                state_q <= StSel;
              end else begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else if (fr_stopped) begin
              state_q <= StIdle;
              mask_q  <= '0;
              busy_q  <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign en_inv_o    = en_inv_q;
  assign en_nand_o   = en_nand_q;
  assign osc_sel_o   = osc_sel_q;
  assign cnt_clear_o = cnt_clear_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_ro_meas_sequencer.sv
// Randomized bench for ro_meas_sequencer with a counter model, a UART busy model and a
// packet-level reference model.

module tb_ro_meas_sequencer;

  localparam int unsigned CntW      = 16;
  localparam int unsigned Window    = 20;
  localparam int unsigned Guard     = 2;
  localparam int unsigned NSampLog2 = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  osc_mask = 2'b00;
  logic        abort = 1'b0;
  logic [15:0] cnt_value = 16'h0000;
  logic        tx_busy = 1'b0;
  logic        en_inv, en_nand, osc_sel, cnt_clear, tx_start, busy, done;
  logic [7:0]  tx_data;
  logic [14:0] all_outs;

  int checks = 0;
  int errors = 0;

  int unsigned sample_q[$];
  logic [7:0]  byte_q[$];
  logic [7:0]  exp_q[$];
  logic [15:0] smp[8];
  int          busy_cnt = 0;
  bit          hold_busy = 1'b0;
  int done_cnt = 0, clr_cnt = 0, start_cnt = 0, overlap = 0;
  int inv_win = 0, nand_win = 0, bad_win = 0, inv_run = 0, nand_run = 0;

  ro_meas_sequencer #(
    .CntW      (CntW),
    .Window    (Window),
    .Guard     (Guard),
    .NSampLog2 (NSampLog2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start),
    .osc_mask_i  (osc_mask),
    .abort_i     (abort),
    .cnt_value_i (cnt_value),
    .tx_busy_i   (tx_busy),
    .en_inv_o    (en_inv),
    .en_nand_o   (en_nand),
    .osc_sel_o   (osc_sel),
    .cnt_clear_o (cnt_clear),
    .tx_start_o  (tx_start),
    .tx_data_o   (tx_data),
    .busy_o      (busy),
    .done_o      (done)
  );

  assign all_outs = {en_inv, en_nand, osc_sel, cnt_clear, tx_start, tx_data, busy, done};

  always #5 clk = ~clk;

  // UART busy for 10 cycles per strobe, counter returns the next queued sample per clear.
  always @(negedge clk) begin
    if (tx_start) begin
      byte_q.push_back(tx_data);
      busy_cnt = 10;
      start_cnt++;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy = (busy_cnt > 0) || hold_busy;
    if (cnt_clear) begin
      clr_cnt++;
      if (sample_q.size() > 0) cnt_value = 16'(sample_q.pop_front());
    end
    if (done) done_cnt++;
    if (en_inv && en_nand) overlap++;
    if (en_inv) inv_run++;
    else if (inv_run > 0) begin
      inv_win++;
      if (inv_run != Window) bad_win++;
      inv_run = 0;
    end
    if (en_nand) nand_run++;
    else if (nand_run > 0) begin
      nand_win++;
      if (nand_run != Window) bad_win++;
      nand_run = 0;
    end
  end

  task automatic clear_stats();
    byte_q.delete();
    exp_q.delete();
    sample_q.delete();
    done_cnt = 0; clr_cnt = 0; start_cnt = 0; overlap = 0;
    inv_win = 0; nand_win = 0; bad_win = 0;
  endtask

  // Reference model: queue the samples in measurement order and predict the packets.
  task automatic load_samples(input logic [1:0] mask);
    for (int o = 0; o < 2; o++) begin
      if (mask[o]) begin
        int unsigned sum = 0;
        bit ovf = 1'b0;
        logic [15:0] avg;
        for (int s = 0; s < 4; s++) begin
          sample_q.push_back(int'(smp[o*4+s]));
          sum += int'(smp[o*4+s]);
          if (smp[o*4+s] == 16'hFFFF) ovf = 1'b1;
        end
        avg = 16'(sum / 4);
        exp_q.push_back(8'hA5);
        exp_q.push_back({ovf, 6'b000000, (o == 1)});
        exp_q.push_back(avg[15:8]);
        exp_q.push_back(avg[7:0]);
      end
    end
  endtask

  task automatic randomize_samples();
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 3) == 0) smp[i] = 16'hFFFF;
      else smp[i] = 16'($urandom_range(0, 65535));
    end
  endtask

  task automatic run_seq(input logic [1:0] mask, output bit timeout);
    @(negedge clk); start = 1'b1; osc_mask = mask;
    @(negedge clk); start = 1'b0; osc_mask = 2'b00;
    timeout = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin
        timeout = 1'b0;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (all_outs !== 15'h0) begin
      errors++; $display("FAIL reset_outs got %h want 0", all_outs);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (all_outs !== 15'h0) begin
      errors++; $display("FAIL idle_outs got %h want 0", all_outs);
    end
  endtask

  task automatic test_single_inv();
    bit to;
    clear_stats();
    for (int i = 0; i < 8; i++) smp[i] = 16'h1234;
    load_samples(2'b01);
    run_seq(2'b01, to);
    checks++;
    if (to) begin errors++; $display("FAIL inv_timeout got 1 want 0"); end
    checks++;
    if (byte_q.size() != exp_q.size()) begin
      errors++; $display("FAIL inv_len got %0d want %0d", byte_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++) begin
      checks++;
      if (byte_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL inv_byte%0d got %h want %h", i, byte_q[i], exp_q[i]);
      end
    end
    checks++;
    if (inv_win != 4 || nand_win != 0 || bad_win != 0) begin
      errors++;
      $display("FAIL inv_windows got inv=%0d nand=%0d bad=%0d want 4/0/0", inv_win, nand_win,
               bad_win);
    end
    checks++;
    if (clr_cnt != 4) begin errors++; $display("FAIL inv_clears got %0d want 4", clr_cnt); end
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL inv_done got done=%0d busy=%b want 1/0", done_cnt, busy);
    end
  endtask

  task automatic test_dual();
    bit to;
    clear_stats();
    for (int i = 0; i < 4; i++) smp[i] = 16'(100 + i);
    for (int i = 4; i < 8; i++) smp[i] = 16'hFFFF;
    load_samples(2'b11);
    run_seq(2'b11, to);
    checks++;
    if (to || byte_q.size() != 8) begin
      errors++; $display("FAIL dual_len got %0d (timeout %0d) want 8", byte_q.size(), to);
    end
    for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++) begin
      checks++;
      if (byte_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL dual_byte%0d got %h want %h", i, byte_q[i], exp_q[i]);
      end
    end
    checks++;
    if (overlap != 0 || inv_win != 4 || nand_win != 4 || bad_win != 0) begin
      errors++;
      $display("FAIL dual_windows got ovl=%0d inv=%0d nand=%0d bad=%0d want 0/4/4/0", overlap,
               inv_win, nand_win, bad_win);
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL dual_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_random();
    bit to;
    logic [1:0] mask;
    for (int it = 0; it < 5; it++) begin
      clear_stats();
      randomize_samples();
      mask = 2'($urandom_range(1, 3));
      load_samples(mask);
      run_seq(mask, to);
      checks++;
      if (to || byte_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rnd%0d_len got %0d want %0d", it, byte_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++) begin
        checks++;
        if (byte_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rnd%0d_byte%0d got %h want %h", it, i, byte_q[i], exp_q[i]);
        end
      end
      checks++;
      if (done_cnt != 1 || overlap != 0 || bad_win != 0) begin
        errors++;
        $display("FAIL rnd%0d_ctl got done=%0d ovl=%0d bad=%0d want 1/0/0", it, done_cnt,
                 overlap, bad_win);
      end
    end
  endtask

  task automatic test_ignored_start();
    bit to;
    clear_stats();
    @(negedge clk); start = 1'b1; osc_mask = 2'b00;
    @(negedge clk); start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mask0_busy got %b want 0", busy); end
    @(negedge clk); start = 1'b1; osc_mask = 2'b01; abort = 1'b1;
    @(negedge clk); start = 1'b0; osc_mask = 2'b00; abort = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || clr_cnt != 0 || inv_win + nand_win != 0 || start_cnt != 0) begin
      errors++;
      $display("FAIL ignored_activity got busy=%b clr=%0d win=%0d tx=%0d want 0", busy, clr_cnt,
               inv_win + nand_win, start_cnt);
    end
    randomize_samples();
    load_samples(2'b01);
    @(negedge clk); start = 1'b1; osc_mask = 2'b01;
    @(negedge clk); start = 1'b0; osc_mask = 2'b00;
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (i == 30) begin start = 1'b1; osc_mask = 2'b11; end
      else begin start = 1'b0; osc_mask = 2'b00; end
      if (done) begin to = 1'b0; break; end
    end
    start = 1'b0; osc_mask = 2'b00;
    repeat (60) @(negedge clk);
    checks++;
    if (to || byte_q.size() != 4 || nand_win != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL busy_start got bytes=%0d nand=%0d done=%0d want 4/0/1", byte_q.size(),
               nand_win, done_cnt);
    end
    for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++) begin
      checks++;
      if (byte_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL busy_start_byte%0d got %h want %h", i, byte_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_abort_window();
    bit to;
    int rises = 0;
    bit prev = 1'b0;
    clear_stats();
    randomize_samples();
    load_samples(2'b01);
    @(negedge clk); start = 1'b1; osc_mask = 2'b01;
    @(negedge clk); start = 1'b0; osc_mask = 2'b00;
    to = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (en_inv && !prev) rises++;
      prev = en_inv;
      if (rises == 2) begin to = 1'b0; break; end
    end
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++;
    if (to || en_inv !== 1'b0) begin
      errors++; $display("FAIL abort_win_en got en=%b timeout=%0d want 0/0", en_inv, to);
    end
    repeat (200) @(negedge clk);
    checks++;
    if (start_cnt != 0 || done_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_win_after got tx=%0d done=%0d busy=%b want 0/0/0", start_cnt,
               done_cnt, busy);
    end
    clear_stats();
    randomize_samples();
    load_samples(2'b11);
    run_seq(2'b11, to);
    checks++;
    if (to || byte_q.size() != 8 || done_cnt != 1) begin
      errors++;
      $display("FAIL abort_rerun got bytes=%0d done=%0d want 8/1", byte_q.size(), done_cnt);
    end
    for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++) begin
      checks++;
      if (byte_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL abort_rerun_byte%0d got %h want %h", i, byte_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_abort_send();
    int n = 0;
    clear_stats();
    randomize_samples();
    load_samples(2'b01);
    @(negedge clk); start = 1'b1; osc_mask = 2'b01;
    @(negedge clk); start = 1'b0; osc_mask = 2'b00;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx_start) n++;
      if (n == 2) break;
    end
    hold_busy = 1'b1;
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (n != 2 || busy !== 1'b1 || start_cnt != 2) begin
      errors++;
      $display("FAIL abort_send_hold got seen=%0d busy=%b tx=%0d want 2/1/2", n, busy, start_cnt);
    end
    hold_busy = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (start_cnt != 2 || done_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_send_end got tx=%0d done=%0d busy=%b want 2/0/0", start_cnt,
               done_cnt, busy);
    end
    checks++;
    if (byte_q.size() < 2 || byte_q[0] !== exp_q[0] || byte_q[1] !== exp_q[1]) begin
      errors++; $display("FAIL abort_send_bytes got %0d bytes want A5 then id", byte_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int hi = 0;
    clear_stats();
    randomize_samples();
    load_samples(2'b11);
    @(negedge clk); start = 1'b1; osc_mask = 2'b11;
    @(negedge clk); start = 1'b0; osc_mask = 2'b00;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (en_inv) hi++;
      if (hi == 5) break;
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (hi != 5 || all_outs !== 15'h0) begin
      errors++; $display("FAIL reset_window got outs=%h hi=%0d want 0/5", all_outs, hi);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    clear_stats();
    randomize_samples();
    load_samples(2'b01);
    @(negedge clk); start = 1'b1; osc_mask = 2'b01;
    @(negedge clk); start = 1'b0; osc_mask = 2'b00;
    to = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx_start) begin to = 1'b0; break; end
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (to || all_outs !== 15'h0) begin
      errors++; $display("FAIL reset_send got outs=%h timeout=%0d want 0/0", all_outs, to);
    end
    reset = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (done_cnt != 0 || start_cnt != 1) begin
      errors++;
      $display("FAIL reset_send_after got done=%0d tx=%0d want 0/1", done_cnt, start_cnt);
    end
    clear_stats();
    for (int i = 0; i < 8; i++) smp[i] = 16'(8 * i + 3);
    load_samples(2'b11);
    run_seq(2'b11, to);
    checks++;
    if (to || byte_q.size() != 8 || done_cnt != 1) begin
      errors++;
      $display("FAIL reset_rerun got bytes=%0d done=%0d want 8/1", byte_q.size(), done_cnt);
    end
    for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++) begin
      checks++;
      if (byte_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL reset_rerun_byte%0d got %h want %h", i, byte_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_inv();
    test_dual();
    test_random();
    test_ignored_start();
    test_abort_window();
    test_abort_send();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ro_meas_sequencer.md
Name: ro_meas_sequencer

Overview:
Measurement scheduler for the ring-oscillator temperature sensor. It time-shares the single edge counter between the inverter and NAND ring oscillators. For each enabled oscillator it runs 2^NSAMP_LOG2 gated counting windows of fixed length and averages the samples. It then streams a framed result packet through the UART transmitter. It sits between the host command decode, the oscillator enables/mux, the counter and the UART tx port.

Parameters:
CNT_W, 16, width of the shared edge counter value
WINDOW, 10000, clk cycles the selected oscillator is enabled per sample (>=2)
GUARD, 4, clk cycles between oscillator enable change and counter clear/sample (>=2)
NSAMP_LOG2, 3, log2 of samples averaged per oscillator (0..6)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle request to run a measurement sequence
osc_mask  in  2  bit0 = measure inverter osc, bit1 = measure NAND osc; sampled on accepted start
abort  in  1  level; stop sequence at next safe point
cnt_value  in  CNT_W  shared counter output
tx_busy  in  1  UART transmitter busy
en_inv  out  1  inverter oscillator enable
en_nand  out  1  NAND oscillator enable
osc_sel  out  1  counter input mux select (0 = inv, 1 = nand)
cnt_clear  out  1  one-cycle counter clear
tx_start  out  1  one-cycle UART send strobe
tx_data  out  8  byte to send, valid while tx_start = 1
busy  out  1  sequence in progress
done  out  1  one-cycle pulse when the final byte of the packet has completed

Behaviour:
- Reset (sync, active-high): all outputs 0, state IDLE, accumulator 0, latched mask 0. Reset mid-sequence drops the enables the next cycle; no packet byte is completed.
- IDLE: start=1 with osc_mask!=0 is accepted: latch mask, busy=1 next cycle, go to SEL. start with mask=0 is ignored. start while busy is ignored.
- SEL: osc_sel = lowest pending oscillator (inv first); sample index=0, acc=0.
- SETTLE: GUARD cycles, enables 0; cnt_clear=1 on the last cycle.
- WINDOW: the selected enable (en_inv or en_nand, never both) =1 for exactly WINDOW cycles; osc_sel stable.
- DRAIN: enable 0 for GUARD cycles (synchronizer flush). Then capture cnt_value.
- ACCUM: acc += cnt_value. acc width = CNT_W+NSAMP_LOG2, so it never overflows. If cnt_value == all-ones, set sticky ovf flag for this oscillator. If index < 2^NSAMP_LOG2-1: index++ and go to SETTLE. Otherwise avg = acc >> NSAMP_LOG2 (truncating) and go to SEND.
- SEND packet per oscillator, 4 bytes, in order:
  - 0xA5
  - id byte {ovf, 6'b0, osc_sel}
  - avg[15:8]
  - avg[7:0]
  - For CNT_W<16, avg is zero-extended to 16 bits.
- Byte handshake:
  - Wait for tx_busy=0, then pulse tx_start 1 cycle with tx_data.
  - Ignore tx_busy for the following cycle, then wait for tx_busy=0 before the next byte.
  - tx_data holds its value until the next tx_start.
- After 4 bytes: clear the mask bit; if another bit is pending go to SEL, else go to IDLE with done=1 for 1 cycle and busy=0.
- Total cycles per oscillator before SEND = 2^NSAMP_LOG2*(2*GUARD+WINDOW+1).
- abort:
  - In SETTLE/WINDOW/DRAIN/ACCUM: enables 0 next cycle, go to IDLE, no done pulse, no bytes sent.
  - In SEND: finish the current byte handshake only, then IDLE, no done pulse.
  - abort and start in the same IDLE cycle: start is ignored.

Decomposition:
- Shared package: state encoding constants, the header constant 0xA5, and osc id constants OSC_INV=0, OSC_NAND=1.
- One sub-module is natural: meas_tx_framer. It takes the 4-byte packet load, runs the tx_start/tx_busy handshake and returns a byte-done/packet-done strobe. The top FSM handles windows and averaging.

Test Plan:
All tests use WINDOW=20, GUARD=2, NSAMP_LOG2=2, with a counter model returning a programmable value and a UART model with busy=1 for 10 cycles after tx_start.
1. start, mask=01, cnt_value=0x1234 every sample -> en_inv high for exactly 20 cycles x4, en_nand never high; bytes A5,00,12,34; done once; busy low afterwards.
2. mask=11, inv samples 100,101,102,103 and nand samples 0xFFFF x4 -> packet A5,00,00,65 then A5,81,FF,FF (ovf set); enables never overlap.
3. start with mask=00, and start asserted while busy -> no enable activity, no extra packet.
4. abort in the 2nd WINDOW -> enable drops next cycle, no tx_start, no done, returns to IDLE; a fresh start then runs a full correct sequence.
5. abort during the 2nd byte, with tx_busy held -> that byte completes, no further tx_start, no done.
6. reset asserted in WINDOW and in SEND -> all outputs 0 the next cycle; avg of a following run is unaffected by stale accumulator contents.
